// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with run-time din1 signedness, arithmetic right shift,
// saturate-or-wrap output, overflow flag and valid/ready flow control.
module myproject_mul_pipe_sat #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 37,
    parameter int SHIFT      = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din1_signed,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W  = din0_WIDTH + din1_WIDTH + 1;
    localparam int EW = (W > dout_WIDTH) ? W : dout_WIDTH;
    localparam int NS = NUM_STAGE + 0 * ID;

    logic signed [din1_WIDTH:0] din1_ext;
    logic signed [W-1:0]        prod;
    logic                       adv;

    assign din1_ext = {din1_signed & din1[din1_WIDTH-1], din1};
    assign prod     = W'($signed(din0)) * W'(din1_ext);

    // The full-width product is carried through the pipe; shift and range
    // handling act on the last stage so every stage holds the same word.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_stage
            logic                valid_reg;
            logic signed [W-1:0] prod_reg;
            logic                src_valid;
            logic signed [W-1:0] src_prod;

            if (gi == 0) begin : g_src
                assign src_valid = in_valid;
                assign src_prod  = prod;
            end else begin : g_src
                assign src_valid = g_stage[gi-1].valid_reg;
                assign src_prod  = g_stage[gi-1].prod_reg;
            end

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    valid_reg <= 1'b0;
                    prod_reg  <= '0;
                end else if (adv) begin
                    valid_reg <= src_valid;
                    if (src_valid) begin
                        prod_reg <= src_prod;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[NS-1].valid_reg;
    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;

    logic signed [W-1:0]              shifted;
    logic signed [EW-1:0]             shifted_ext;
    logic        [EW-dout_WIDTH:0]    high_bits;
    logic                             fits;

    assign shifted     = g_stage[NS-1].prod_reg >>> SHIFT;
    assign shifted_ext = EW'(shifted);
    // Value fits when every bit from the dout sign position upward agrees.
    assign high_bits   = shifted_ext[EW-1:dout_WIDTH-1];
    assign fits        = (&high_bits) | ~(|high_bits);
    assign ovf         = ~fits;

    always_comb begin
        dout = shifted_ext[dout_WIDTH-1:0];
        if (!fits && SATURATE != 0) begin
            dout = shifted_ext[EW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                     : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
    end

endmodule
